// File: rtl/packer_pkg.sv
// Shared defaults and lane/word types for the byte-to-word packer.
package packer_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 4;
    localparam int unsigned DEF_IDX_WIDTH      = $clog2(DEF_BYTES_PER_WORD);

    typedef logic [DEF_DATA_WIDTH-1:0]        lane_t;
    typedef lane_t [DEF_BYTES_PER_WORD-1:0]   word_t;
    typedef logic [DEF_IDX_WIDTH-1:0]         lane_idx_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into BYTES_PER_WORD-lane words; in_last flushes a partial word.
// Build option PACKER_MSB_FIRST_EN selects big-endian lane fill (first byte in the top lane).
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int unsigned CNT_WIDTH      = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH-1:0]                      in_byte,
    input  logic                                       in_last,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  out_word,
    output logic [CNT_WIDTH-1:0]                       out_count,
    output logic [15:0]                                word_cnt
);

    localparam int unsigned IDX_WIDTH = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_WORD - 1);

    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] out_word_q;
    logic [IDX_WIDTH-1:0]                      idx_q;
    logic [IDX_WIDTH-1:0]                      pos;
    logic [CNT_WIDTH-1:0]                      out_count_q;
    logic                                      out_valid_q;
    logic [15:0]                               word_cnt_q;
    logic                                      in_fire;
    logic                                      out_fire;
    logic                                      complete;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign complete = in_fire && ((idx_q == LAST_IDX) || in_last);

`ifdef PACKER_MSB_FIRST_EN
    assign pos = LAST_IDX - idx_q;
`else
    assign pos = idx_q;
`endif

    // Accumulator is cleared on every completion, so unwritten lanes are already zero.
    always_comb begin
        acc_d      = acc_q;
        acc_d[pos] = in_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_word_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            if (out_fire) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (complete) begin
                out_word_q  <= acc_d;
                out_count_q <= CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                idx_q       <= '0;
            end else begin
                if (out_fire) begin
                    out_valid_q <= 1'b0;
                end
                if (in_fire) begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDX_WIDTH'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_count = out_count_q;
    assign word_cnt  = word_cnt_q;

endmodule
